// File: rtl/lap_memory_ctrl.sv
// Lap-time store for a stopwatch: circular register array with a stepped display.
// Define LAP_OVERWRITE_EN to make a write while full replace the oldest lap.
module lap_memory_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     clear,
    input  logic                     write,
    input  logic                     read,
    input  logic [WIDTH-1:0]         time_in,
    output logic [WIDTH-1:0]         lap_out,
    output logic [$clog2(DEPTH)-1:0] lap_index,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     valid
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] FULL_CNT = (IW + 1)'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    old_q, old_d;
    logic [IW-1:0]    wr_q, wr_d;
    logic [IW:0]      count_q, count_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] lap_q, lap_d;
    logic [IW-1:0]    rd_addr;
    logic             mem_we;

    always_comb begin
        state_d = state_q;
        old_d   = old_q;
        wr_d    = wr_q;
        count_d = count_q;
        idx_d   = idx_q;
        lap_d   = lap_q;
        rd_addr = old_q;
        mem_we  = 1'b0;

        if (clear) begin
            state_d = IDLE;
            old_d   = '0;
            wr_d    = '0;
            count_d = '0;
            idx_d   = '0;
            lap_d   = '0;
        end else begin
            if (write) begin
                if (count_q != FULL_CNT) begin
                    mem_we  = 1'b1;
                    wr_d    = wr_q + 1'b1;
                    count_d = count_q + 1'b1;
                end
`ifdef LAP_OVERWRITE_EN
                else begin
                    // when full wr_q == old_q, so this replaces the oldest lap
                    mem_we = 1'b1;
                    wr_d   = wr_q + 1'b1;
                    old_d  = old_q + 1'b1;
                end
`endif
            end
            // read sees pre-edge count and contents, so a same-cycle write stays hidden
            if (read) begin
                if (state_q == SHOW) begin
                    if ({1'b0, idx_q} == count_q - 1'b1) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                    rd_addr = old_q + idx_d;
                    lap_d   = mem_q[rd_addr];
                end else if (count_q != '0) begin
                    state_d = SHOW;
                    idx_d   = '0;
                    rd_addr = old_q;
                    lap_d   = mem_q[rd_addr];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            old_q   <= '0;
            wr_q    <= '0;
            count_q <= '0;
            idx_q   <= '0;
            lap_q   <= '0;
        end else begin
            state_q <= state_d;
            old_q   <= old_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            lap_q   <= lap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_q] <= time_in;
        end
    end

    assign lap_out   = lap_q;
    assign lap_index = idx_q;
    assign count     = count_q;
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign valid     = (state_q == SHOW);

endmodule

// File: tb/tb_lap_memory_ctrl.sv
// Bench for lap_memory_ctrl: vector table through a scoreboard queue,
// plus reset corner cases; follows LAP_OVERWRITE_EN when defined.
module tb_lap_memory_ctrl;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         nrst = 1'b1;
    logic         clear = 1'b0;
    logic         write = 1'b0;
    logic         read = 1'b0;
    logic [W-1:0] time_in = '0;
    logic [W-1:0] lap_out;
    logic [2:0]   lap_index;
    logic [3:0]   count;
    logic         full;
    logic         empty;
    logic         valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         c;
        logic         w;
        logic         r;
        logic [W-1:0] t;
        logic [W-1:0] lap;
        logic [2:0]   idx;
        logic [3:0]   cnt;
        logic         v;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    lap_memory_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .nrst(nrst), .clear(clear), .write(write), .read(read),
        .time_in(time_in), .lap_out(lap_out), .lap_index(lap_index),
        .count(count), .full(full), .empty(empty), .valid(valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t e);
        chk({tag, ".lap"}, 32'(lap_out), 32'(e.lap));
        chk({tag, ".idx"}, 32'(lap_index), 32'(e.idx));
        chk({tag, ".cnt"}, 32'(count), 32'(e.cnt));
        chk({tag, ".valid"}, 32'(valid), 32'(e.v));
        chk({tag, ".full"}, 32'(full), 32'(e.cnt == 4'(D)));
        chk({tag, ".empty"}, 32'(empty), 32'(e.cnt == 4'd0));
    endtask

    task automatic add(input logic c, input logic w, input logic r,
                       input logic [W-1:0] t, input logic [W-1:0] lap,
                       input logic [2:0] idx, input logic [3:0] cnt,
                       input logic v);
        vec_t x;
        x.c = c; x.w = w; x.r = r; x.t = t;
        x.lap = lap; x.idx = idx; x.cnt = cnt; x.v = v;
        vecs.push_back(x);
    endtask

    task automatic run_vecs(input string grp);
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            clear   = vecs[i].c;
            write   = vecs[i].w;
            read    = vecs[i].r;
            time_in = vecs[i].t;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_outs($sformatf("%s%0d", grp, i), e);
        end
        clear = 0; write = 0; read = 0;
        vecs.delete();
    endtask

    task automatic check_reset(input string tag);
        vec_t e;
        e.c = 0; e.w = 0; e.r = 0; e.t = '0;
        e.lap = '0; e.idx = '0; e.cnt = '0; e.v = 0;
        check_outs(tag, e);
    endtask

    initial begin
        #1 nrst = 1'b0;
        #2 check_reset("rst0");
        @(posedge clk);
        #2 nrst = 1'b1;
        @(posedge clk);
        #1;

        // c w r  time     lap      idx cnt valid
        add(0, 1, 0, 16'h10, 16'h0,  0, 1, 0);
        add(0, 1, 0, 16'h20, 16'h0,  0, 2, 0);
        add(0, 1, 0, 16'h30, 16'h0,  0, 3, 0);
        add(0, 0, 1, 16'h0,  16'h10, 0, 3, 1);
        add(0, 0, 1, 16'h0,  16'h20, 1, 3, 1);
        add(0, 0, 1, 16'h0,  16'h30, 2, 3, 1);
        add(0, 0, 1, 16'h0,  16'h10, 0, 3, 1);
        add(0, 0, 0, 16'h0,  16'h10, 0, 3, 1);
        add(0, 1, 1, 16'h40, 16'h20, 1, 4, 1);
        add(0, 1, 0, 16'h50, 16'h20, 1, 5, 1);
        add(1, 1, 0, 16'h60, 16'h0,  0, 0, 0);
        add(0, 0, 1, 16'h0,  16'h0,  0, 0, 0);
        add(0, 1, 0, 16'hA,  16'h0,  0, 1, 0);
        add(0, 1, 0, 16'hB,  16'h0,  0, 2, 0);
        add(0, 0, 1, 16'h0,  16'hA,  0, 2, 1);
        add(0, 0, 1, 16'h0,  16'hB,  1, 2, 1);
        add(0, 1, 1, 16'hC,  16'hA,  0, 3, 1);
        add(0, 0, 1, 16'h0,  16'hB,  1, 3, 1);
        add(0, 0, 1, 16'h0,  16'hC,  2, 3, 1);
        add(1, 0, 0, 16'h0,  16'h0,  0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            add(0, 1, 0, 16'(i), 16'h0, 0, 4'((i > D) ? D : i), 0);
        end
        for (int k = 0; k <= 8; k++) begin
`ifdef LAP_OVERWRITE_EN
            add(0, 0, 1, 16'h0, 16'((k % D) + 2), 3'(k % D), 4'(D), 1);
`else
            add(0, 0, 1, 16'h0, 16'((k % D) + 1), 3'(k % D), 4'(D), 1);
`endif
        end
        run_vecs("a");

        #2 nrst = 1'b0;
        #1 check_reset("rst_mid");
        #2 nrst = 1'b1;
        @(posedge clk);
        #1;

        add(0, 0, 1, 16'h0,  16'h0,  0, 0, 0);
        add(0, 1, 1, 16'h77, 16'h0,  0, 1, 0);
        add(0, 0, 1, 16'h0,  16'h77, 0, 1, 1);
        add(0, 0, 1, 16'h0,  16'h77, 0, 1, 1);
        run_vecs("b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
